// File: rtl/fp16_pkg.sv
// Shared fp16 constants and the divider FSM state type.
package fp16_pkg;

  localparam int FP16_EXP_BIAS = 15;
  localparam logic [15:0] FP16_QNAN = 16'h7E00;
  localparam logic [15:0] FP16_POS_INF = 16'h7C00;

  typedef enum logic [1:0] {StIdle, StDivide, StNorm} state_t;

endpackage

// File: rtl/significand_divider.sv
// Restoring significand divider: one quotient bit per step, MSB first.
// quotient = (dividend << (MAN_WIDTH+1)) / divisor, valid once the last step has run.
module significand_divider #(
  parameter int unsigned MAN_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 reset_b,
  input  logic                 load,
  input  logic                 step,
  input  logic [MAN_WIDTH:0]   dividend,
  input  logic [MAN_WIDTH:0]   divisor,
  output logic [MAN_WIDTH+1:0] quotient,
  output logic                 last
);

  localparam int unsigned QW   = MAN_WIDTH + 2;
  localparam int unsigned Iter = MAN_WIDTH + 2;

  logic [QW-1:0]      rem_q;
  logic [MAN_WIDTH:0] div_q;
  logic [QW-1:0]      quo_q;
  logic [3:0]         cnt_q;

  logic          ge;
  logic [QW-1:0] rem_sel;

  always_comb begin
    ge      = rem_q >= {1'b0, div_q};
    rem_sel = ge ? (rem_q - {1'b0, div_q}) : rem_q;
  end

  always_ff @(posedge clk) begin
    if (reset_b) begin
      rem_q <= '0;
      div_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      rem_q <= {1'b0, dividend};
      div_q <= divisor;
      quo_q <= '0;
      cnt_q <= '0;
    end else if (step) begin
      // Remainder after subtraction is below the divisor, so the shift cannot overflow.
      rem_q <= {rem_sel[QW-2:0], 1'b0};
      quo_q <= {quo_q[QW-2:0], ge};
      cnt_q <= cnt_q + 4'd1;
    end
  end

  assign quotient = quo_q;
  assign last     = (cnt_q == 4'(Iter - 1));

endmodule

// File: rtl/fp16_divider.sv
// Iterative fp16 divider (DAZ, truncating). Special operands resolve in one cycle,
// normal operands take 14. Define FP16_DIV_FLAGS_EN to add the flags output.
module fp16_divider
  import fp16_pkg::*;
#(
  parameter int unsigned EXP_WIDTH = 5,
  parameter int unsigned MAN_WIDTH = 10
) (
  input  logic                           clk,
  input  logic                           reset_b,
  input  logic                           start,
  input  logic [EXP_WIDTH+MAN_WIDTH:0]   input_a,
  input  logic [EXP_WIDTH+MAN_WIDTH:0]   input_b,
  output logic                           busy,
  output logic                           valid,
  output logic [EXP_WIDTH+MAN_WIDTH:0]   result
`ifdef FP16_DIV_FLAGS_EN
  ,
  output logic [2:0]                     flags
`endif
);

  localparam int unsigned W      = 1 + EXP_WIDTH + MAN_WIDTH;
  localparam int unsigned QW     = MAN_WIDTH + 2;
  localparam int unsigned ExpMax = (1 << EXP_WIDTH) - 1;

  state_t                 state_q;
  logic [EXP_WIDTH-1:0]   exp_a_q, exp_b_q;
  logic                   sign_q;

  logic [EXP_WIDTH-1:0]   exp_a, exp_b;
  logic [MAN_WIDTH-1:0]   man_a, man_b;
  logic                   a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sign_ab;

  assign exp_a   = input_a[W-2 -: EXP_WIDTH];
  assign exp_b   = input_b[W-2 -: EXP_WIDTH];
  assign man_a   = input_a[MAN_WIDTH-1:0];
  assign man_b   = input_b[MAN_WIDTH-1:0];
  assign a_zero  = (exp_a == '0);
  assign b_zero  = (exp_b == '0);
  assign a_inf   = (exp_a == '1) && (man_a == '0);
  assign b_inf   = (exp_b == '1) && (man_b == '0);
  assign a_nan   = (exp_a == '1) && (man_a != '0);
  assign b_nan   = (exp_b == '1) && (man_b != '0);
  assign sign_ab = input_a[W-1] ^ input_b[W-1];

  logic         special;
  logic [W-1:0] special_res;
`ifdef FP16_DIV_FLAGS_EN
  logic         special_dbz;
`endif

  always_comb begin
    special     = 1'b1;
    special_res = '0;
`ifdef FP16_DIV_FLAGS_EN
    special_dbz = 1'b0;
`endif
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      special_res = FP16_QNAN;
    end else if (a_inf || b_zero) begin
      special_res = {sign_ab, FP16_POS_INF[W-2:0]};
`ifdef FP16_DIV_FLAGS_EN
      special_dbz = ~a_inf;
`endif
    end else if (a_zero || b_inf) begin
      special_res = '0;
    end else begin
      special = 1'b0;
    end
  end

  logic [QW-1:0] quotient;
  logic          div_last;
  logic          div_load;

  assign div_load = (state_q == StIdle) && start && !special;

  significand_divider #(
    .MAN_WIDTH (MAN_WIDTH)
  ) u_significand_divider (
    .clk      (clk),
    .reset_b  (reset_b),
    .load     (div_load),
    .step     (state_q == StDivide),
    .dividend ({1'b1, man_a}),
    .divisor  ({1'b1, man_b}),
    .quotient (quotient),
    .last     (div_last)
  );

  int                   e_norm;
  logic [MAN_WIDTH-1:0] man_norm;
  logic                 ovf, unf;
  logic [W-1:0]         norm_res;

  always_comb begin
    e_norm   = int'(exp_a_q) - int'(exp_b_q) + FP16_EXP_BIAS;
    man_norm = quotient[MAN_WIDTH:1];
    // Quotient lies in [2^(QW-2), 2^QW): at most one position of normalisation shift.
    if (!quotient[QW-1]) begin
      e_norm   = e_norm - 1;
      man_norm = quotient[MAN_WIDTH-1:0];
    end
    ovf = (e_norm >= int'(ExpMax));
    unf = (e_norm <= 0);
    if (ovf) begin
      norm_res = {sign_q, FP16_POS_INF[W-2:0]};
    end else if (unf) begin
      norm_res = '0;
    end else begin
      norm_res = {sign_q, e_norm[EXP_WIDTH-1:0], man_norm};
    end
  end

  always_ff @(posedge clk) begin
    if (reset_b) begin
      state_q <= StIdle;
      exp_a_q <= '0;
      exp_b_q <= '0;
      sign_q  <= 1'b0;
      busy    <= 1'b0;
      valid   <= 1'b0;
      result  <= '0;
`ifdef FP16_DIV_FLAGS_EN
      flags   <= '0;
`endif
    end else begin
      valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start && special) begin
            result <= special_res;
            valid  <= 1'b1;
`ifdef FP16_DIV_FLAGS_EN
            flags  <= {special_dbz, 2'b00};
`endif
          end else if (start) begin
            exp_a_q <= exp_a;
            exp_b_q <= exp_b;
            sign_q  <= sign_ab;
            busy    <= 1'b1;
            state_q <= StDivide;
          end
        end
        StDivide: begin
          if (div_last) state_q <= StNorm;
        end
        StNorm: begin
          result  <= norm_res;
          valid   <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
`ifdef FP16_DIV_FLAGS_EN
          flags   <= {1'b0, ovf, unf};
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_divider.sv
// Self-checking bench for fp16_divider: directed cases, timing profile,
// start/reset interference and a randomized run against a behavioural model.
module tb_fp16_divider;

  logic        clk = 1'b0;
  logic        reset_b;
  logic        start;
  logic [15:0] a, b;
  logic        busy, valid;
  logic [15:0] result;
`ifdef FP16_DIV_FLAGS_EN
  logic [2:0]  flags;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp16_divider dut (
    .clk     (clk),
    .reset_b (reset_b),
    .start   (start),
    .input_a (a),
    .input_b (b),
    .busy    (busy),
    .valid   (valid),
    .result  (result)
`ifdef FP16_DIV_FLAGS_EN
    ,
    .flags   (flags)
`endif
  );

  // Behavioural reference: real-number quotient of the two significands scaled by 2^11.
  function automatic logic [15:0] ref_div(input logic [15:0] x, input logic [15:0] y,
                                          output logic [2:0] fl, output bit spec);
    int ex, ey, mx, my, q, e, man;
    bit zx, zy, ix, iy, nx, ny;
    logic s;
    ex = int'(x[14:10]); ey = int'(y[14:10]);
    mx = int'(x[9:0]);   my = int'(y[9:0]);
    s  = x[15] ^ y[15];
    zx = (ex == 0); zy = (ey == 0);
    ix = (ex == 31) && (mx == 0); iy = (ey == 31) && (my == 0);
    nx = (ex == 31) && (mx != 0); ny = (ey == 31) && (my != 0);
    fl = 3'b000;
    spec = 1'b1;
    if (nx || ny || (zx && zy) || (ix && iy)) return 16'h7E00;
    if (ix || zy) begin
      if (!ix) fl = 3'b100;
      return {s, 15'h7C00};
    end
    if (zx || iy) return 16'h0000;
    spec = 1'b0;
    q = ((1024 + mx) * 2048) / (1024 + my);
    if (q >= 2048) begin
      man = (q / 2) % 1024;
      e   = ex - ey + 15;
    end else begin
      man = q % 1024;
      e   = ey > 99 ? 0 : ex - ey + 14;
    end
    if (e >= 31) begin
      fl = 3'b010;
      return {s, 15'h7C00};
    end
    if (e <= 0) begin
      fl = 3'b001;
      return 16'h0000;
    end
    return {s, 5'(e), 10'(man)};
  endfunction

  // Issues one request at the current negedge and waits (bounded) for valid.
  task automatic run_op(input logic [15:0] oa, input logic [15:0] ob,
                        output logic [15:0] res, output int lat);
    a = oa; b = ob; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    res = 16'hxxxx;
    for (int c = 1; c <= 30; c++) begin
      if (valid) begin
        lat = c;
        res = result;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset_b = 1'b1; start = 1'b0; a = 16'h0; b = 16'h0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
    checks++; if (result !== 16'h0000) begin errors++; $display("FAIL reset_result got %h want 0000", result); end
`ifdef FP16_DIV_FLAGS_EN
    checks++; if (flags !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", flags); end
`endif
    reset_b = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [15:0] tv_a [5] = '{16'h4200, 16'h3C00, 16'hC600, 16'h7BFF, 16'h0000};
    logic [15:0] tv_b [5] = '{16'h3E00, 16'h4200, 16'h0000, 16'h0400, 16'h0000};
    logic [15:0] tv_r [5] = '{16'h4000, 16'h3555, 16'hFC00, 16'h7C00, 16'h7E00};
    int          tv_l [5] = '{14, 14, 1, 14, 1};
    logic [2:0]  tv_f [5] = '{3'b000, 3'b000, 3'b100, 3'b010, 3'b000};
    logic [15:0] res;
    int          lat;
    for (int i = 0; i < 5; i++) begin
      run_op(tv_a[i], tv_b[i], res, lat);
      checks++;
      if (res !== tv_r[i]) begin
        errors++; $display("FAIL directed_result[%0d] got %h want %h", i, res, tv_r[i]);
      end
      checks++;
      if (lat != tv_l[i]) begin
        errors++; $display("FAIL directed_latency[%0d] got %0d want %0d", i, lat, tv_l[i]);
      end
`ifdef FP16_DIV_FLAGS_EN
      checks++;
      if (flags !== tv_f[i]) begin
        errors++; $display("FAIL directed_flags[%0d] got %b want %b", i, flags, tv_f[i]);
      end
`else
      if (tv_f[i] === 3'bxxx) $display("unreachable");
`endif
      @(negedge clk);
    end
  endtask

  task automatic test_busy_profile();
    a = 16'h4200; b = 16'h3E00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      checks++;
      if (busy !== (c <= 13)) begin
        errors++; $display("FAIL busy_profile cycle %0d got %b want %b", c, busy, c <= 13);
      end
      checks++;
      if (valid !== (c == 14)) begin
        errors++; $display("FAIL valid_profile cycle %0d got %b want %b", c, valid, c == 14);
      end
      @(negedge clk);
    end
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL valid_single_pulse got %b want 0", valid); end
  endtask

  task automatic test_ignore_start();
    int n_valid = 0, at = -1;
    logic [15:0] got = 16'hxxxx;
    a = 16'h4200; b = 16'h3E00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      if (valid) begin n_valid++; at = c; got = result; end
      start = (c == 5);
      if (c == 5) begin a = 16'h3C00; b = 16'h4200; end
      @(negedge clk);
    end
    checks++; if (n_valid != 1) begin errors++; $display("FAIL ignore_start_count got %0d want 1", n_valid); end
    checks++; if (at != 14) begin errors++; $display("FAIL ignore_start_latency got %0d want 14", at); end
    checks++; if (got !== 16'h4000) begin errors++; $display("FAIL ignore_start_result got %h want 4000", got); end
  endtask

  task automatic test_reset_abort();
    int n_valid = 0;
    a = 16'h4200; b = 16'h3E00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      if (c == 8) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        checks++;
        if (result !== 16'h0000) begin errors++; $display("FAIL abort_result got %h want 0000", result); end
        reset_b = 1'b0; start = 1'b0;
      end
      if (valid) n_valid++;
      if (c == 7) begin
        // Start held during reset must be ignored too.
        reset_b = 1'b1; start = 1'b1; a = 16'h3C00; b = 16'h4200;
      end
      @(negedge clk);
    end
    checks++; if (n_valid != 0) begin errors++; $display("FAIL abort_valid_count got %0d want 0", n_valid); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] res;
    int lat;
    run_op(16'h4200, 16'h3E00, res, lat);
    checks++; if (res !== 16'h4000) begin errors++; $display("FAIL b2b_first got %h want 4000", res); end
    run_op(16'h3C00, 16'h4200, res, lat);
    checks++; if (res !== 16'h3555) begin errors++; $display("FAIL b2b_second got %h want 3555", res); end
    checks++; if (lat != 14) begin errors++; $display("FAIL b2b_latency got %0d want 14", lat); end
    @(negedge clk);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_low got %b want 0", valid); end
  endtask

  function automatic logic [15:0] rand_operand();
    int sel;
    logic [4:0] e;
    logic [9:0] m;
    sel = int'($urandom_range(0, 15));
    m = 10'($urandom);
    if (sel == 0) e = 5'd0;
    else if (sel == 1) begin e = 5'd31; if ($urandom_range(0, 1) == 0) m = 10'd0; end
    else e = 5'($urandom_range(1, 30));
    return {1'($urandom), e, m};
  endfunction

  task automatic test_random();
    logic [15:0] ra, rb, exp_res, res;
    logic [2:0]  exp_fl;
    bit          spec;
    int          lat;
    for (int i = 0; i < 150; i++) begin
      ra = rand_operand();
      rb = rand_operand();
      exp_res = ref_div(ra, rb, exp_fl, spec);
      run_op(ra, rb, res, lat);
      checks++;
      if (res !== exp_res) begin
        errors++; $display("FAIL random_result %h/%h got %h want %h", ra, rb, res, exp_res);
      end
      checks++;
      if (lat != (spec ? 1 : 14)) begin
        errors++; $display("FAIL random_latency %h/%h got %0d want %0d", ra, rb, lat, spec ? 1 : 14);
      end
`ifdef FP16_DIV_FLAGS_EN
      checks++;
      if (flags !== exp_fl) begin
        errors++; $display("FAIL random_flags %h/%h got %b want %b", ra, rb, flags, exp_fl);
      end
`endif
    end
  endtask

  initial begin
    start = 1'b0; reset_b = 1'b1; a = '0; b = '0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_busy_profile();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
